// File: rtl/hdc_pkg.sv
// Shared HDC back-end definitions: default geometry, derived widths and the
// classifier controller state encoding.
package hdc_pkg;

  localparam int DIMENSIONS_DEF = 10000;
  localparam int CHUNK_DEF      = 100;

  // Distance width: must hold the full range 0..dims inclusive.
  function automatic int calc_dw(input int dims);
    return $clog2(dims + 1);
  endfunction

  function automatic int calc_num_chunks(input int dims, input int chunk);
    return dims / chunk;
  endfunction

  // Chunk index width; a single-chunk configuration still needs one bit.
  function automatic int calc_idx_w(input int num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } sim_state_e;

endpackage

// File: rtl/chunk_popcount.sv
// Combinational Hamming distance of one CHUNK-wide slice: popcount(a ^ b).
module chunk_popcount #(
  parameter int CHUNK = 100
) (
  input  logic [CHUNK-1:0]            i_a,
  input  logic [CHUNK-1:0]            i_b,
  output logic [$clog2(CHUNK+1)-1:0]  o_count
);

  localparam int PW = $clog2(CHUNK + 1);

  logic [CHUNK-1:0] w_diff;

  assign w_diff = i_a ^ i_b;

  // Sum the differing bit positions of the slice.
  always_comb begin
    o_count = {PW{1'b0}};
    for (int i = 0; i < CHUNK; i++) begin
      o_count = o_count + PW'(w_diff[i]);
    end
  end

endmodule

// File: rtl/similarity_ctrl.sv
// Multi-cycle Hamming-distance classifier: walks the query and both class
// prototypes chunk by chunk, accumulates both distances, then presents a
// registered label/distance result under a valid/ready handshake.
module similarity_ctrl
  import hdc_pkg::*;
#(
  parameter int DIMENSIONS = DIMENSIONS_DEF,
  parameter int CHUNK      = CHUNK_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DIMENSIONS-1:0]             hv,
  input  logic [DIMENSIONS-1:0]             ns_hv,
  input  logic [DIMENSIONS-1:0]             s_hv,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              label_out,
  output logic [$clog2(DIMENSIONS+1)-1:0]   dist_ns,
  output logic [$clog2(DIMENSIONS+1)-1:0]   dist_s
);

  localparam int DW         = calc_dw(DIMENSIONS);
  localparam int NUM_CHUNKS = calc_num_chunks(DIMENSIONS, CHUNK);
  localparam int IDX_W      = calc_idx_w(NUM_CHUNKS);
  localparam int PW         = $clog2(CHUNK + 1);

  if ((DIMENSIONS % CHUNK) != 0) begin : g_bad_chunk
    $error("similarity_ctrl: DIMENSIONS must be an exact multiple of CHUNK");
  end

  sim_state_e       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [DW-1:0]    r_acc_ns;
  logic [DW-1:0]    r_acc_s;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_label;
  logic [DW-1:0]    r_dist_ns;
  logic [DW-1:0]    r_dist_s;

  logic [CHUNK-1:0] w_hv_chunk;
  logic [CHUNK-1:0] w_ns_chunk;
  logic [CHUNK-1:0] w_s_chunk;
  logic [PW-1:0]    w_pc_ns;
  logic [PW-1:0]    w_pc_s;

  // Indexed part-select keeps the chunk mux narrow instead of shifting full vectors.
  assign w_hv_chunk = hv[r_idx * CHUNK +: CHUNK];
  assign w_ns_chunk = ns_hv[r_idx * CHUNK +: CHUNK];
  assign w_s_chunk  = s_hv[r_idx * CHUNK +: CHUNK];

  chunk_popcount #(.CHUNK(CHUNK)) u_pc_ns (
    .i_a     (w_hv_chunk),
    .i_b     (w_ns_chunk),
    .o_count (w_pc_ns)
  );

  chunk_popcount #(.CHUNK(CHUNK)) u_pc_s (
    .i_a     (w_hv_chunk),
    .i_b     (w_s_chunk),
    .o_count (w_pc_s)
  );

  // Controller FSM with chunk walk, accumulation and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= {IDX_W{1'b0}};
      r_acc_ns    <= {DW{1'b0}};
      r_acc_s     <= {DW{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_label     <= 1'b0;
      r_dist_ns   <= {DW{1'b0}};
      r_dist_s    <= {DW{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state    <= ACCUM;
            r_idx      <= {IDX_W{1'b0}};
            r_acc_ns   <= {DW{1'b0}};
            r_acc_s    <= {DW{1'b0}};
            r_in_ready <= 1'b0;
          end
        end
        ACCUM: begin
          r_acc_ns <= r_acc_ns + DW'(w_pc_ns);
          r_acc_s  <= r_acc_s + DW'(w_pc_s);
          if (r_idx == IDX_W'(NUM_CHUNKS - 1)) begin
            r_idx   <= {IDX_W{1'b0}};
            r_state <= COMPARE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        COMPARE: begin
          // Ties go to the seizure class.
          r_label     <= (r_acc_ns < r_acc_s) ? 1'b0 : 1'b1;
          r_dist_ns   <= r_acc_ns;
          r_dist_s    <= r_acc_s;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_idx       <= {IDX_W{1'b0}};
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign label_out = r_label;
  assign dist_ns   = r_dist_ns;
  assign dist_s    = r_dist_s;

endmodule
